systolic_seq_ctrl: RTL
======================

# systolic_seq_ctrl

Sequencing controller for the 8x8 signed systolic matrix-multiply array. It holds operand matrices A and B and, on `start`, clears the array accumulators. It then injects the row- and column-skewed operand wavefronts, drains the pipeline, captures the post-activation result matrix into a readback buffer, and reports completion. It sits between the host/load logic and the array instance: its feed outputs drive the array's `A_in`/`B_in`, and it samples the array's `C_out`.

## Interface
- `N`, 8, array dimension (rows = cols)
- `DATA_WIDTH`, 16, signed operand width
- `ACC_WIDTH`, 32, signed result width
- `DRAIN_CYCLES`, 10, zero-feed cycles after the last wavefront
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `load_we`  in  1  operand write strobe
- `load_sel`  in  1  0 = A, 1 = B
- `load_row`, `load_col`  in  $clog2(N) each  element index
- `load_data`  in  DATA_WIDTH  signed element
- `start`  in  1  begin a multiply (level, sampled in IDLE only)
- `busy`  out  1  high from CLEAR through CAPTURE
- `done`  out  1  one-cycle pulse after capture
- `res_valid`  out  1  result buffer holds a completed product
- `arr_clr`  out  1  active-high accumulator clear to array (top inverts for array `rst_n`)
- `a_feed`  out  N x DATA_WIDTH  to array `A_in[i]`
- `b_feed`  out  N x DATA_WIDTH  to array `B_in[j]`
- `arr_c`  in  N x N x ACC_WIDTH  array `C_out`
- `res_row`, `res_col`  in  $clog2(N) each  readback index
- `res_data`  out  ACC_WIDTH  combinational read of result buffer
- `perf_cycles`  out  32  busy-cycle counter (see Configuration)

## Operation
- FSM states: IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE.
- IDLE -> CLEAR when `start` = 1. CLEAR -> FEED after 1 cycle. FEED -> DRAIN after 2N-1 cycles. DRAIN -> CAPTURE after DRAIN_CYCLES cycles. CAPTURE -> DONE after 1 cycle. DONE -> IDLE after 1 cycle.
- Step counter t runs 0..2N-2 in FEED and 0..DRAIN_CYCLES-1 in DRAIN.
- In FEED step t: `a_feed[i]` = A[i][t-i] if 0 <= t-i < N, else 0. `b_feed[j]` = B[t-j][j` if 0 <= t-j < N, else 0.
- In all other states, `a_feed` and `b_feed` are 0.
- Feeds are registered, so step t values are stable for the whole FEED cycle t.
- `arr_clr` = 1 only during CLEAR.
- CAPTURE latches all N*N `arr_c` values into the result buffer and sets `res_valid`.
- `start` accepted out of IDLE clears `res_valid`.
- Loads are accepted only in IDLE and DONE. `load_we` while `busy` is silently dropped.
- `load_we` and `start` in the same IDLE cycle: the write commits on that edge and is included in the multiply.
- `start` while busy or in DONE is ignored; `start` is not queued.
- No arithmetic in the block: operands and results are passed through unmodified (signed).

## Timing
- Reset values: state IDLE, `busy`/`done`/`res_valid`/`arr_clr` = 0, feeds = 0, A/B/result storage all 0, `perf_cycles` = 0.
- Reset asserted in any state returns to IDLE on the next edge; an aborted run leaves `res_valid` = 0.
- `start` sampled high at edge k:
  - CLEAR during cycle k+1.
  - FEED during cycles k+2..k+2N (15 cycles).
  - DRAIN during cycles k+2N+1..k+2N+DRAIN_CYCLES.
  - CAPTURE during cycle k+2N+DRAIN_CYCLES+1.
  - `done` high during cycle k+2N+DRAIN_CYCLES+2 (k+28 at defaults).
- `res_data` is valid from the DONE cycle onward and holds until the next accepted `start`.
- Earliest restart: `start` sampled in the first IDLE cycle after DONE.

## Configuration
- `SYSTOLIC_CTRL_PERF_EN` defined: `perf_cycles` increments every cycle `busy` = 1, saturates at 2^32-1, and is cleared only by `rst`.
- `SYSTOLIC_CTRL_PERF_EN` undefined: the counter is not built and `perf_cycles` is tied to 0.

## Structure
- Shared package `systolic_pkg`: FSM state enum, `N`/width defaults, and the operand/result element typedefs used by the array and top level.
- One natural sub-module, `systolic_skew_gen`: operand storage plus the step-t skewed feed selection.
- The FSM, capture buffer and counter stay in `systolic_seq_ctrl`.

## Test plan
- Load A[i][j]=8i+j+1 and B[i][j]=64-(8i+j), start, connect the real array -> `done` at start+28, C[0][0]=960, all 64 entries match the software product.
- Same load, monitor feeds -> t=0: `a_feed`={1,0,...,0}; t=7: `a_feed[0]`=8, `a_feed[7]`=57, `b_feed[0]`=8; t=14: only `a_feed[7]`=64 and `b_feed[7]`=1 are nonzero.
- `load_we` during FEED, then re-run the multiply -> the dropped write is not visible; results are unchanged.
- Assert `rst` during DRAIN -> the next cycle shows IDLE, `busy`=0, `res_valid`=0, feeds 0, and no `done` pulse.
- `start` held high continuously -> back-to-back runs with `done` pulses 29 cycles apart; a `start` pulse mid-run is ignored.
- With `SYSTOLIC_CTRL_PERF_EN`: one run gives `perf_cycles`=27; without the macro it reads 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types for the 8x8 signed systolic array and its sequencing controller.
package systolic_pkg;

    localparam int N                = 8;
    localparam int DATA_WIDTH       = 16;
    localparam int ACC_WIDTH        = 32;
    localparam int DEF_DRAIN_CYCLES = 10;
    localparam int IDX_W            = $clog2(N);

    typedef logic signed [DATA_WIDTH-1:0] data_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_t;
    typedef logic [IDX_W-1:0]             idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Host-side bus of the systolic sequencer: operand loading, run control and result readback.
interface systolic_seq_ctrl_if;
    import systolic_pkg::*;

    logic        load_we;
    logic        load_sel;
    idx_t        load_row;
    idx_t        load_col;
    data_t       load_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        res_valid;
    idx_t        res_row;
    idx_t        res_col;
    acc_t        res_data;
    logic [31:0] perf_cycles;

    modport master (
        output load_we, load_sel, load_row, load_col, load_data, start, res_row, res_col,
        input  busy, done, res_valid, res_data, perf_cycles
    );

    modport slave (
        input  load_we, load_sel, load_row, load_col, load_data, start, res_row, res_col,
        output busy, done, res_valid, res_data, perf_cycles
    );

endinterface

// File: rtl/systolic_skew_gen.sv
// Operand storage for A and B plus the registered, row/column-skewed wavefront feeds.
module systolic_skew_gen
    import systolic_pkg::*;
#(
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic              load_sel,
    input  idx_t              load_row,
    input  idx_t              load_col,
    input  data_t             load_data,
    input  logic              feed_en,
    input  logic [STEP_W-1:0] step,
    output data_t             a_feed [N],
    output data_t             b_feed [N]
);

    data_t a_mem [N][N];
    data_t b_mem [N][N];
    data_t a_sel [N];
    data_t b_sel [N];

    // Lane i carries element k when step == i + k; the skew is symmetric for rows of A and columns of B.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_sel[i] = '0;
            b_sel[i] = '0;
            for (int k = 0; k < N; k++) begin
                if (int'(step) == i + k) begin
                    a_sel[i] = a_mem[i][k];
                    b_sel[i] = b_mem[k][i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                a_feed[i] <= '0;
                b_feed[i] <= '0;
                for (int j = 0; j < N; j++) begin
                    a_mem[i][j] <= '0;
                    b_mem[i][j] <= '0;
                end
            end
        end else begin
            if (load_we) begin
                if (load_sel)
                    b_mem[load_row][load_col] <= load_data;
                else
                    a_mem[load_row][load_col] <= load_data;
            end
            for (int i = 0; i < N; i++) begin
                a_feed[i] <= feed_en ? a_sel[i] : '0;
                b_feed[i] <= feed_en ? b_sel[i] : '0;
            end
        end
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencing controller for the 8x8 systolic multiply: clear, feed, drain, capture, done.
// Optional busy-cycle counter is built when SYSTOLIC_CTRL_PERF_EN is defined.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    systolic_seq_ctrl_if.slave  host,
    output logic                arr_clr,
    output data_t               a_feed [N],
    output data_t               b_feed [N],
    input  acc_t                arr_c  [N][N]
);

    localparam int STEP_W = $clog2(max_int(2*N-1, DRAIN_CYCLES));
    localparam logic [STEP_W-1:0] FEED_LAST  = STEP_W'(2*N-2);
    localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'(DRAIN_CYCLES-1);

    state_t            state, state_nxt;
    logic [STEP_W-1:0] step, step_nxt;
    logic              busy;
    logic              load_ok;
    acc_t              res_buf [N][N];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            step  <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = '0;
        case (state)
            ST_IDLE:    if (host.start) state_nxt = ST_CLEAR;
            ST_CLEAR:   state_nxt = ST_FEED;
            ST_FEED:    if (step == FEED_LAST) state_nxt = ST_DRAIN;
                        else step_nxt = step + STEP_W'(1);
            ST_DRAIN:   if (step == DRAIN_LAST) state_nxt = ST_CAPTURE;
                        else step_nxt = step + STEP_W'(1);
            ST_CAPTURE: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    assign busy      = (state == ST_CLEAR) || (state == ST_FEED) ||
                       (state == ST_DRAIN) || (state == ST_CAPTURE);
    assign load_ok   = (state == ST_IDLE) || (state == ST_DONE);
    assign arr_clr   = (state == ST_CLEAR);
    assign host.busy = busy;
    assign host.done = (state == ST_DONE);

    // Feeds are computed from the next state so step t is already on the wires for all of FEED cycle t.
    systolic_skew_gen #(.STEP_W(STEP_W)) u_skew (
        .clk       (clk),
        .rst       (rst),
        .load_we   (host.load_we && load_ok),
        .load_sel  (host.load_sel),
        .load_row  (host.load_row),
        .load_col  (host.load_col),
        .load_data (host.load_data),
        .feed_en   (state_nxt == ST_FEED),
        .step      (step_nxt),
        .a_feed    (a_feed),
        .b_feed    (b_feed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            host.res_valid <= 1'b0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    res_buf[i][j] <= '0;
        end else if (state == ST_CAPTURE) begin
            res_buf        <= arr_c;
            host.res_valid <= 1'b1;
        end else if (state == ST_IDLE && host.start) begin
            host.res_valid <= 1'b0;
        end
    end

    assign host.res_data = res_buf[host.res_row][host.res_col];

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf;

    always_ff @(posedge clk) begin
        if (rst)
            perf <= '0;
        else if (busy && perf != '1)
            perf <= perf + 32'd1;
    end

    assign host.perf_cycles = perf;
`else
    assign host.perf_cycles = '0;
`endif

endmodule
